// File: rtl/decode_pkg.sv
// Shared RV64I decode definitions: opcode encodings, operation classes and
// immediate formats used by the decode stage and its immediate generator.
package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_ILLEGAL  = 4'd0,
        CLS_LUI      = 4'd1,
        CLS_AUIPC    = 4'd2,
        CLS_JAL      = 4'd3,
        CLS_JALR     = 4'd4,
        CLS_BRANCH   = 4'd5,
        CLS_LOAD     = 4'd6,
        CLS_STORE    = 4'd7,
        CLS_OP_IMM   = 4'd8,
        CLS_OP_IMM32 = 4'd9,
        CLS_OP       = 4'd10,
        CLS_OP32     = 4'd11,
        CLS_FENCE    = 4'd12,
        CLS_SYSTEM   = 4'd13
    } op_class_t;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_t;

    function automatic imm_type_t imm_type_of(input op_class_t cls);
        imm_type_t t;
        case (cls)
            CLS_LUI, CLS_AUIPC:   t = IMM_U;
            CLS_JAL:              t = IMM_J;
            CLS_BRANCH:           t = IMM_B;
            CLS_STORE:            t = IMM_S;
            CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_OP_IMM32,
            CLS_FENCE, CLS_SYSTEM: t = IMM_I;
            default:              t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV64I immediate generator: assembles the immediate for the
// given format and sign-extends it from instr[31] to 64 bits.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    input  imm_type_t   imm_type_i,
    output logic [63:0] imm_o
);

    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    always_comb begin
        imm_o = '0;
        case (imm_type_i)
            IMM_I: imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// RV64I decode stage: selects the instruction half of a fetched cache word,
// decodes it and holds the result in a single-entry valid/ready register.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned      XLEN         = 64,
    parameter logic [XLEN-1:0]  RESET_PC_TAG = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [63:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output op_class_t       out_class,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic [31:0] sel_instr;
    op_class_t   dec_class;
    imm_type_t   dec_imm_type;
    logic [63:0] dec_imm;

    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    op_class_t       class_q;
    logic [XLEN-1:0] imm_q;

    assign sel_instr = in_pc[2] ? in_instr[63:32] : in_instr[31:0];

    always_comb begin
        dec_class = CLS_ILLEGAL;
        case (sel_instr[6:0])
            OPC_LUI:      dec_class = CLS_LUI;
            OPC_AUIPC:    dec_class = CLS_AUIPC;
            OPC_JAL:      dec_class = CLS_JAL;
            OPC_JALR:     dec_class = CLS_JALR;
            OPC_BRANCH:   dec_class = CLS_BRANCH;
            OPC_LOAD:     dec_class = CLS_LOAD;
            OPC_STORE:    dec_class = CLS_STORE;
            OPC_OP_IMM:   dec_class = CLS_OP_IMM;
            OPC_OP_IMM32: dec_class = CLS_OP_IMM32;
            OPC_OP:       dec_class = CLS_OP;
            OPC_OP32:     dec_class = CLS_OP32;
            OPC_FENCE:    dec_class = CLS_FENCE;
            OPC_SYSTEM:   dec_class = CLS_SYSTEM;
            default:      dec_class = CLS_ILLEGAL;
        endcase
        // Non-32-bit encodings and misaligned fetch addresses are both undecodable
        if (sel_instr[1:0] != 2'b11 || in_pc[1:0] != 2'b00) begin
            dec_class = CLS_ILLEGAL;
        end
    end

    assign dec_imm_type = imm_type_of(dec_class);

    imm_gen u_imm_gen (
        .instr_i    (sel_instr),
        .imm_type_i (dec_imm_type),
        .imm_o      (dec_imm)
    );

    assign in_ready = !reset && (state_q == EMPTY || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept)         state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC_TAG;
            instr_q     <= '0;
            class_q     <= CLS_ILLEGAL;
            imm_q       <= '0;
        end else if (accept) begin
            pc_q        <= in_pc;
            instr_q     <= sel_instr;
            class_q     <= dec_class;
            imm_q       <= dec_imm;
        end
    end

    // Register fields are slices of the held instruction, so they stay stable with it
    assign out_valid   = (state_q == FULL);
    assign out_pc      = pc_q;
    assign out_instr   = instr_q;
    assign out_class   = class_q;
    assign out_rd      = instr_q[11:7];
    assign out_rs1     = instr_q[19:15];
    assign out_rs2     = instr_q[24:20];
    assign out_funct3  = instr_q[14:12];
    assign out_funct7  = instr_q[31:25];
    assign out_imm     = imm_q;
    assign out_illegal = (class_q == CLS_ILLEGAL) && (state_q == FULL || instr_q != '0);

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: directed and random traffic with
// a reference decoder built from the RV64I encoding rules.
module tb_instr_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_instr, in_pc, out_pc, out_imm;
    logic [31:0] out_instr;
    op_class_t   out_class;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_illegal;

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(64), .RESET_PC_TAG(64'h0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_class(out_class), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_imm(out_imm), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [3:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   model_full = 1'b0;
    bit   held_prev = 1'b0;
    exp_t prev_snap;

    logic [6:0] opc_list [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                  7'h13, 7'h1B, 7'h33, 7'h3B, 7'h0F, 7'h73};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [63:0] pc, input logic [63:0] word);
        exp_t   e;
        logic [31:0] w;
        longint imm;
        op_class_t c;
        w = pc[2] ? word[63:32] : word[31:0];
        imm = 0;
        case (w[6:0])
            7'h37: begin c = CLS_LUI;      imm = longint'($signed({w[31:12], 12'h000})); end
            7'h17: begin c = CLS_AUIPC;    imm = longint'($signed({w[31:12], 12'h000})); end
            7'h6F: begin c = CLS_JAL;      imm = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
            7'h67: begin c = CLS_JALR;     imm = longint'($signed(w[31:20])); end
            7'h63: begin c = CLS_BRANCH;   imm = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
            7'h03: begin c = CLS_LOAD;     imm = longint'($signed(w[31:20])); end
            7'h23: begin c = CLS_STORE;    imm = longint'($signed({w[31:25], w[11:7]})); end
            7'h13: begin c = CLS_OP_IMM;   imm = longint'($signed(w[31:20])); end
            7'h1B: begin c = CLS_OP_IMM32; imm = longint'($signed(w[31:20])); end
            7'h33: c = CLS_OP;
            7'h3B: c = CLS_OP32;
            7'h0F: begin c = CLS_FENCE;    imm = longint'($signed(w[31:20])); end
            7'h73: begin c = CLS_SYSTEM;   imm = longint'($signed(w[31:20])); end
            default: c = CLS_ILLEGAL;
        endcase
        if (pc[1:0] != 2'b00) begin
            c = CLS_ILLEGAL;
            imm = 0;
        end
        e.pc = pc; e.instr = w; e.cls = c;
        e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.f3 = w[14:12]; e.f7 = w[31:25];
        e.imm = imm; e.ill = (c == CLS_ILLEGAL);
        return e;
    endfunction

    function automatic exp_t snap_dut();
        exp_t s;
        s.pc = out_pc; s.instr = out_instr; s.cls = out_class;
        s.rd = out_rd; s.rs1 = out_rs1; s.rs2 = out_rs2;
        s.f3 = out_funct3; s.f7 = out_funct7; s.imm = out_imm; s.ill = out_illegal;
        return s;
    endfunction

    task automatic cmp_entry(input string tag, input exp_t a, input exp_t e);
        chk({tag, ".pc"},      a.pc,        e.pc);
        chk({tag, ".instr"},   64'(a.instr), 64'(e.instr));
        chk({tag, ".class"},   64'(a.cls),   64'(e.cls));
        chk({tag, ".rd"},      64'(a.rd),    64'(e.rd));
        chk({tag, ".rs1"},     64'(a.rs1),   64'(e.rs1));
        chk({tag, ".rs2"},     64'(a.rs2),   64'(e.rs2));
        chk({tag, ".funct3"},  64'(a.f3),    64'(e.f3));
        chk({tag, ".funct7"},  64'(a.f7),    64'(e.f7));
        chk({tag, ".imm"},     a.imm,        e.imm);
        chk({tag, ".illegal"}, 64'(a.ill),   64'(e.ill));
    endtask

    // Monitor: an entry leaves the stage when consumed or flushed while held
    always @(negedge clk) begin
        exp_t s;
        if (!reset && out_valid) begin
            s = snap_dut();
            if (held_prev) cmp_entry("hold", s, prev_snap);
            if (out_ready || flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    cmp_entry("out", s, exp_q.pop_front());
                end
            end
            held_prev = !out_ready && !flush;
            prev_snap = s;
        end else begin
            held_prev = 1'b0;
        end
    end

    task automatic step(input bit v, input logic [63:0] word, input logic [63:0] pc,
                        input bit ordy, input bit fl);
        bit rdy, acc;
        @(posedge clk);
        #2;
        in_valid = v; in_instr = word; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
        rdy = !model_full || ordy;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("out_valid", 64'(out_valid), 64'(model_full));
        acc = v && rdy && !fl;
        if (acc) exp_q.push_back(ref_decode(pc, word));
        if (fl)        model_full = 1'b0;
        else if (acc)  model_full = 1'b1;
        else if (ordy) model_full = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.out_valid",   64'(out_valid),   64'd0);
        chk("rst.out_pc",      out_pc,           64'h0);
        chk("rst.out_instr",   64'(out_instr),   64'd0);
        chk("rst.out_class",   64'(out_class),   64'(CLS_ILLEGAL));
        chk("rst.out_rd",      64'(out_rd),      64'd0);
        chk("rst.out_rs1",     64'(out_rs1),     64'd0);
        chk("rst.out_rs2",     64'(out_rs2),     64'd0);
        chk("rst.out_funct3",  64'(out_funct3),  64'd0);
        chk("rst.out_funct7",  64'(out_funct7),  64'd0);
        chk("rst.out_imm",     out_imm,          64'h0);
        chk("rst.out_illegal", 64'(out_illegal), 64'd0);
        exp_q.delete();
        model_full = 1'b0;
        #1;
        reset = 1'b0;
    endtask

    task automatic gen(output logic [63:0] word, output logic [63:0] pc);
        logic [31:0] w;
        int unsigned r;
        w = $urandom;
        r = $urandom_range(0, 15);
        if (r < 13) w[6:0] = opc_list[r];
        pc = {32'($urandom), 32'($urandom)};
        pc[1:0] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        word = pc[2] ? {w, 32'($urandom)} : {32'($urandom), w};
    endtask

    initial begin
        logic [63:0] w, p;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        do_reset();

        step(1, {32'hDEADBEEF, 32'h00500093}, 64'h1000, 1, 0);
        step(1, {32'hFE20AE23, 32'h00000000}, 64'h1004, 1, 0);
        step(1, {32'h00000000, 32'hFF9FF06F}, 64'h1008, 1, 0);
        step(1, {32'h123452B7, 32'h00000000}, 64'h100C, 1, 0);
        step(1, {32'h00000000, 32'h800002B7}, 64'h1010, 1, 0);
        step(1, {32'h00000000, 32'h00000000}, 64'h1018, 1, 0);
        step(1, {32'hFFFFFFFF, 32'h00000000}, 64'h101C, 1, 0);
        step(1, {32'h00000000, 32'h00500093}, 64'h1002, 1, 0);
        step(0, '0, '0, 1, 0);

        // Backpressure: held entry must stay put and the stalled input must not be lost
        step(1, {32'h0, 32'h00A00113}, 64'h2000, 1, 0);
        repeat (3) step(1, {32'h0, 32'h01400193}, 64'h2008, 0, 0);
        step(1, {32'h0, 32'h01400193}, 64'h2008, 1, 0);
        step(0, '0, '0, 1, 0);

        // Flush while held and stalled, then flush together with out_ready
        step(1, {32'h0, 32'h00100213}, 64'h3000, 1, 0);
        step(1, {32'h0, 32'h00200293}, 64'h3008, 0, 1);
        step(0, '0, '0, 1, 0);
        step(1, {32'h0, 32'h00300313}, 64'h3010, 1, 0);
        step(1, {32'h0, 32'h00400393}, 64'h3018, 1, 1);
        step(0, '0, '0, 0, 0);

        // Reset in the middle of a held entry
        step(1, {32'h0, 32'h123452B7}, 64'h4000, 1, 0);
        step(1, {32'h0, 32'h00500093}, 64'h4008, 0, 0);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            gen(w, p);
            step($urandom_range(0, 3) != 0, w, p, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0);
        end

        repeat (3) step(0, '0, '0, 1, 0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Decode stage directly downstream of the instruction fetcher.
- Accepts a fetched 64-bit cache word plus its fetch address, and selects the 32-bit RV64I instruction half using address bit 2.
- Decodes the instruction into register indices, function fields, an operation class and a sign-extended 64-bit immediate.
- Holds the result in a single-entry pipeline register with valid/ready handshakes on both sides and a flush input for redirects.

Parameters:
- XLEN, 64, data/address width.
- RESET_PC_TAG, 64'h0, value driven on out_pc while empty/after reset.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  discard held and incoming instruction (branch redirect)
- in_valid  in  1  fetcher result valid (fetcher_done)
- in_ready  out  1  stage can accept this cycle
- in_instr  in  64  fetched cache word
- in_pc  in  XLEN  fetch address of the word
- out_valid  out  1  decoded entry held
- out_ready  in  1  execute stage accepts entry
- out_pc  out  XLEN  instruction PC
- out_instr  out  32  selected raw instruction
- out_class  out  4  op class (package enum)
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_funct3  out  3  funct3 field
- out_funct7  out  7  funct7 field
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  undecodable instruction

Behaviour:
- Reset: out_valid=0, out_pc=RESET_PC_TAG, out_instr=0, out_class=CLS_ILLEGAL, out_rd/rs1/rs2=0, out_funct3=0, out_funct7=0, out_imm=0, out_illegal=0.
- State is the out_valid bit: EMPTY (0) / FULL (1).
- in_ready = !out_valid || out_ready. This is combinational, and in_ready is 0 during reset.
- Accept when in_valid && in_ready && !flush. The output register loads next edge, giving 1-cycle latency.
- EMPTY -> FULL on accept.
- FULL -> EMPTY on out_ready && !accept.
- FULL -> FULL with new data on out_ready && accept, for back-to-back throughput of 1 per cycle.
- FULL && !out_ready: all out_* hold stable and in_ready=0.
- flush has priority over everything except reset. Next cycle out_valid=0 and the incoming instruction is dropped. Data fields may keep stale values but must not be valid.
- Simultaneous flush and out_ready: the entry is treated as consumed, then dropped. Out_valid still goes 0.
- Instruction select: instr = in_pc[2] ? in_instr[63:32] : in_instr[31:0]. A misaligned in_pc[1:0]!=0 sets out_illegal=1.
- Field extraction: rd=[11:7], rs1=[19:15], rs2=[24:20], funct3=[14:12], funct7=[31:25].
- Class by opcode[6:0]: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP_IMM, 0011011 OP_IMM32, 0110011 OP, 0111011 OP32, 0001111 FENCE, 1110011 SYSTEM. Any other opcode, or instr[1:0]!=2'b11, gives CLS_ILLEGAL and out_illegal=1.
- Immediates, sign-extended from instr[31] to 64 bits:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - Classes with no immediate (OP, OP32, ILLEGAL) drive imm=0.
- Illegal instructions still flow through the pipeline with out_illegal=1. There is no stall.

Decomposition:
- Package decode_pkg holds the opcode localparams, the op_class_t enum (4-bit, 14 values), and the imm_type_t enum (I,S,B,U,J,NONE).
- One combinational sub-module, imm_gen (instr[31:0], imm_type -> imm[63:0]).
- The stage module holds the select, class decode and pipeline register.

Test Plan:
- Reset then in_pc=0x1000, in_instr={32'hDEADBEEF,32'h00500093}, out_ready=1 -> next cycle out_valid=1, class OP_IMM, rd=1, rs1=0, imm=0x5, out_pc=0x1000.
- Upper-half select: in_pc=0x1004, in_instr={32'hFE20AE23,32'h0} -> class STORE, rs1=1, rs2=2, funct3=2, imm=0xFFFFFFFFFFFFFFFC.
- Immediate signs:
  - 0xFF9FF06F -> JAL, rd=0, imm=-8 (0xFFFFFFFFFFFFFFF8).
  - 0x123452B7 -> LUI, rd=5, imm=0x12345000.
  - 0x800002B7 -> imm=0xFFFFFFFF80000000.
- Backpressure: FULL with out_ready=0 and in_valid=1 for 3 cycles -> in_ready=0 and outputs unchanged. Raise out_ready -> new entry loads next cycle with no loss and no duplication.
- Flush: FULL, assert flush with in_valid=1 and out_ready=0 -> next cycle out_valid=0 and the incoming instruction is not presented. Reset asserted mid-stream -> all outputs at reset values next cycle.
- Illegal: instr 0x00000000 or 0xFFFFFFFF, or in_pc=0x1002 -> out_illegal=1, class ILLEGAL, imm=0, out_valid=1.
